sd_transfer_sequencer: RTL

Transaction sequencer between the Wishbone-side register file and the SD command/data controllers. It runs one complete SD transaction: command phase, optional multi-block data phase, and optional automatic stop command. It supervises each phase with a programmable timeout and reports completion and error status back to the register file. It owns the `new_command`/`newDat` strobes so that the command and data controllers are never started out of order.

---
 rtl/sd_transfer_sequencer.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/sd_transfer_sequencer.sv
// Sequences one SD transaction: command, optional multi-block data, optional CMD12 stop.
// Optional stop phase is built when SD_SEQ_AUTO_STOP_EN is defined.
module sd_transfer_sequencer #(
  parameter int TIMEOUT_W = 16,
  parameter int BLKCNT_W  = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [5:0]           cmd_index,
  input  logic [31:0]          cmd_argument,
  input  logic                 data_present,
  input  logic                 write_read,
  input  logic [BLKCNT_W-1:0]  block_count,
  input  logic [TIMEOUT_W-1:0] timeout_value,
  input  logic                 abort,
  output logic                 cmd_new,
  output logic [5:0]           cmd_index_o,
  output logic [31:0]          cmd_argument_o,
  input  logic                 cmd_complete,
  input  logic                 cmd_error,
  output logic                 dat_new,
  output logic                 dat_write_read,
  output logic                 dat_multiple,
  input  logic                 dat_block_done,
  input  logic                 dat_complete,
  input  logic                 dat_error,
  output logic                 busy,
  output logic [BLKCNT_W-1:0]  blocks_left,
  output logic                 transfer_done,
  output logic [3:0]           error_status
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SEND_CMD = 3'd1;
  localparam logic [2:0] S_WAIT_CMD = 3'd2;
  localparam logic [2:0] S_SEND_DAT = 3'd3;
  localparam logic [2:0] S_WAIT_DAT = 3'd4;
`ifdef SD_SEQ_AUTO_STOP_EN
  localparam logic [2:0] S_SEND_STOP = 3'd5;
  localparam logic [2:0] S_WAIT_STOP = 3'd6;
`endif
  localparam logic [2:0] S_DONE     = 3'd7;

  logic [2:0]           state, state_nxt;
  logic [3:0]           err_set;
  logic                 tmo_load, tmo_hit, blk_dec, in_wait, send_cmd_nxt;
  logic [TIMEOUT_W-1:0] tmo_cnt, tmo_val;
  logic                 data_present_l;

  function automatic logic [BLKCNT_W-1:0] sat_dec(input logic [BLKCNT_W-1:0] v);
    return (v == '0) ? v : v - BLKCNT_W'(1);
  endfunction

  always_comb begin
    state_nxt = state;
    err_set   = 4'b0000;
    tmo_load  = 1'b0;
    blk_dec   = 1'b0;
    tmo_hit   = (tmo_val != '0) && (tmo_cnt == TIMEOUT_W'(1));
    in_wait   = (state == S_WAIT_CMD) || (state == S_WAIT_DAT);
`ifdef SD_SEQ_AUTO_STOP_EN
    in_wait   = in_wait || (state == S_WAIT_STOP);
`endif
    case (state)
      S_IDLE: if (start) state_nxt = S_SEND_CMD;
      S_SEND_CMD: begin
        tmo_load  = 1'b1;
        state_nxt = S_WAIT_CMD;
      end
      S_WAIT_CMD: begin
        if (cmd_complete)   state_nxt = data_present_l ? S_SEND_DAT : S_DONE;
        else if (cmd_error) begin err_set[2] = 1'b1; state_nxt = S_DONE; end
        else if (tmo_hit)   begin err_set[0] = 1'b1; state_nxt = S_DONE; end
      end
      S_SEND_DAT: begin
        if (blocks_left == '0) begin
          err_set[3] = 1'b1;
          state_nxt  = S_DONE;
        end else begin
          tmo_load  = 1'b1;
          state_nxt = S_WAIT_DAT;
        end
      end
      S_WAIT_DAT: begin
        // A finished block restarts the watchdog, so it also masks a timeout in that cycle.
        blk_dec  = dat_block_done;
        tmo_load = dat_block_done;
        if (dat_complete) begin
`ifdef SD_SEQ_AUTO_STOP_EN
          state_nxt = dat_multiple ? S_SEND_STOP : S_DONE;
`else
          state_nxt = S_DONE;
`endif
        end
        else if (dat_error) begin err_set[3] = 1'b1; state_nxt = S_DONE; end
        else if (tmo_hit && !dat_block_done) begin err_set[1] = 1'b1; state_nxt = S_DONE; end
      end
`ifdef SD_SEQ_AUTO_STOP_EN
      S_SEND_STOP: begin
        tmo_load  = 1'b1;
        state_nxt = S_WAIT_STOP;
      end
      S_WAIT_STOP: begin
        if (cmd_complete)   state_nxt = S_DONE;
        else if (cmd_error) begin err_set[2] = 1'b1; state_nxt = S_DONE; end
        else if (tmo_hit)   begin err_set[0] = 1'b1; state_nxt = S_DONE; end
      end
`endif
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort && (state != S_IDLE) && (state != S_DONE)) begin
      err_set[3] = 1'b1;
      tmo_load   = 1'b0;
      state_nxt  = S_DONE;
    end
    send_cmd_nxt = (state_nxt == S_SEND_CMD);
`ifdef SD_SEQ_AUTO_STOP_EN
    send_cmd_nxt = send_cmd_nxt || (state_nxt == S_SEND_STOP);
`endif
  end

  // Outputs are registered from the next-state decode so each pulse lines up with its state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      busy           <= 1'b0;
      cmd_new        <= 1'b0;
      dat_new        <= 1'b0;
      transfer_done  <= 1'b0;
      error_status   <= 4'b0000;
      blocks_left    <= '0;
      cmd_index_o    <= 6'd0;
      cmd_argument_o <= 32'd0;
      dat_write_read <= 1'b0;
      dat_multiple   <= 1'b0;
      data_present_l <= 1'b0;
      tmo_val        <= '0;
      tmo_cnt        <= '0;
    end else begin
      state         <= state_nxt;
      busy          <= (state_nxt != S_IDLE);
      cmd_new       <= send_cmd_nxt;
      dat_new       <= (state_nxt == S_SEND_DAT) && (blocks_left != '0);
      transfer_done <= (state_nxt == S_DONE);
      if (state == S_IDLE && start) begin
        error_status   <= 4'b0000;
        blocks_left    <= block_count;
        cmd_index_o    <= cmd_index;
        cmd_argument_o <= cmd_argument;
        dat_write_read <= write_read;
        dat_multiple   <= (block_count > BLKCNT_W'(1));
        data_present_l <= data_present;
        tmo_val        <= timeout_value;
      end else begin
        error_status <= error_status | err_set;
        if (blk_dec) blocks_left <= sat_dec(blocks_left);
      end
`ifdef SD_SEQ_AUTO_STOP_EN
      if (state_nxt == S_SEND_STOP) begin
        cmd_index_o    <= 6'd12;
        cmd_argument_o <= 32'd0;
      end
`endif
      if (tmo_load) tmo_cnt <= tmo_val;
      else if (in_wait && tmo_cnt != '0) tmo_cnt <= tmo_cnt - TIMEOUT_W'(1);
    end
  end

endmodule
